// File: rtl/debug_toggle_monitor.sv
// Liveness monitor for the free-running debug toggle bit: counts transitions,
// tracks the largest inter-transition gap, flags stalls and drives a heartbeat LED.
module debug_toggle_monitor #(
   parameter int unsigned TIMEOUT_CYCLES = 4,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned DIV_LOG2       = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_in,
   input  logic                 clear,
   output logic                 alive,
   output logic                 stall_err,
   output logic                 heartbeat_led,
   output logic [CNT_WIDTH-1:0] transition_cnt,
   output logic [15:0]          stall_cnt,
   output logic [15:0]          max_gap
);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RUNNING = 2'd2,
      ST_STALLED = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic                 init_cnt_r;
   logic                 bit_q_r;
   logic                 bit_qq_r;
   logic [15:0]          gap_cnt_r;
   logic [DIV_LOG2-1:0]  div_cnt_r;

   logic                 trans_s;
   logic                 count_s;
   logic                 gap_upd_s;
   logic                 stall_entry_s;
   logic                 gap_run_s;
   logic [16:0]          gap_inc_s;
   logic [15:0]          gap_sat_s;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   assign trans_s   = bit_q_r ^ bit_qq_r;
   assign gap_inc_s = {1'b0, gap_cnt_r} + 17'd1;
   assign gap_sat_s = gap_inc_s[16] ? 16'hFFFF : gap_inc_s[15:0];

   // Two-stage sampling pipe of the upstream toggle bit
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_q_r  <= 1'b0;
         bit_qq_r <= 1'b0;
      end else begin
         bit_q_r  <= bit_in;
         bit_qq_r <= bit_q_r;
      end
   end

   // State register; INIT blanks trans for the two cycles the pipe needs to refill
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_INIT;
         init_cnt_r <= 1'b0;
         alive      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         init_cnt_r <= (state_r == ST_INIT) ? 1'b1 : 1'b0;
         alive      <= (state_nxt_s == ST_RUNNING) ? 1'b1 : 1'b0;
      end
   end

   // Next-state logic; a transition on the timeout cycle keeps the monitor running
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (init_cnt_r) state_nxt_s = ST_ARMED;
            else            state_nxt_s = ST_INIT;
         end
         ST_ARMED: begin
            if (trans_s) state_nxt_s = ST_RUNNING;
            else         state_nxt_s = ST_ARMED;
         end
         ST_RUNNING: begin
            if (!trans_s && (gap_inc_s == 17'(TIMEOUT_CYCLES))) state_nxt_s = ST_STALLED;
            else                                                 state_nxt_s = ST_RUNNING;
         end
         ST_STALLED: begin
            if (trans_s) state_nxt_s = ST_RUNNING;
            else         state_nxt_s = ST_STALLED;
         end
         default: state_nxt_s = ST_INIT;
      endcase
   end

   // Update strobes for the statistics registers
   always_comb begin
      count_s       = 1'b0;
      gap_upd_s     = 1'b0;
      stall_entry_s = 1'b0;
      gap_run_s     = 1'b0;
      case (state_r)
         ST_INIT: begin
            count_s = 1'b0;
         end
         ST_ARMED: begin
            count_s = trans_s;
         end
         ST_RUNNING: begin
            count_s       = trans_s;
            gap_upd_s     = trans_s;
            gap_run_s     = 1'b1;
            stall_entry_s = !trans_s && (gap_inc_s == 17'(TIMEOUT_CYCLES));
         end
         ST_STALLED: begin
            count_s   = trans_s;
            gap_upd_s = trans_s;
            gap_run_s = 1'b1;
         end
         default: begin
            count_s = 1'b0;
         end
      endcase
   end

   // Gap counter: cycles since the last counted transition, unaffected by clear
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt_r <= 16'd0;
      end else if (count_s) begin
         gap_cnt_r <= 16'd0;
      end else if (gap_run_s) begin
         gap_cnt_r <= sat_inc16(gap_cnt_r);
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   // Statistics and heartbeat; clear suppresses any same-cycle update
   always_ff @(posedge clk) begin
      if (rst) begin
         transition_cnt <= '0;
         stall_cnt      <= 16'd0;
         max_gap        <= 16'd0;
         stall_err      <= 1'b0;
         div_cnt_r      <= '0;
         heartbeat_led  <= 1'b0;
      end else if (clear) begin
         transition_cnt <= '0;
         stall_cnt      <= 16'd0;
         max_gap        <= 16'd0;
         stall_err      <= 1'b0;
         div_cnt_r      <= '0;
      end else begin
         if (count_s) begin
            transition_cnt <= transition_cnt + CNT_WIDTH'(1);
            div_cnt_r      <= div_cnt_r + DIV_LOG2'(1);
            if (div_cnt_r == {DIV_LOG2{1'b1}}) heartbeat_led <= ~heartbeat_led;
            else                               heartbeat_led <= heartbeat_led;
         end else begin
            transition_cnt <= transition_cnt;
            div_cnt_r      <= div_cnt_r;
         end
         if (gap_upd_s && (gap_sat_s > max_gap)) max_gap <= gap_sat_s;
         else                                    max_gap <= max_gap;
         if (stall_entry_s) begin
            stall_cnt <= sat_inc16(stall_cnt);
            stall_err <= 1'b1;
         end else begin
            stall_cnt <= stall_cnt;
            stall_err <= stall_err;
         end
      end
   end

endmodule

// File: tb/tb_debug_toggle_monitor.sv
// Randomized bench for debug_toggle_monitor against an event-level reference model.
module tb_debug_toggle_monitor;

   localparam int TIMEOUT = 4;
   localparam int CW      = 4;
   localparam int DL      = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          bit_in;
   logic          clear;
   logic          alive;
   logic          stall_err;
   logic          heartbeat_led;
   logic [CW-1:0] transition_cnt;
   logic [15:0]   stall_cnt;
   logic [15:0]   max_gap;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: edges since reset, edge of last counted transition, totals
   logic m_q, m_qq;
   int   n_edge, last_edge, tcnt, scnt, mgap, ndiv;
   bit   started, stalled, serr, hb;
   logic cur;

   debug_toggle_monitor #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .CNT_WIDTH     (CW),
      .DIV_LOG2      (DL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bit_in        (bit_in),
      .clear         (clear),
      .alive         (alive),
      .stall_err     (stall_err),
      .heartbeat_led (heartbeat_led),
      .transition_cnt(transition_cnt),
      .stall_cnt     (stall_cnt),
      .max_gap       (max_gap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input logic b, input logic c, input logic r);
      int   gap;
      logic tr;
      if (r) begin
         m_q = 1'b0; m_qq = 1'b0;
         n_edge = 0; last_edge = 0; tcnt = 0; scnt = 0; mgap = 0; ndiv = 0;
         started = 1'b0; stalled = 1'b0; serr = 1'b0; hb = 1'b0;
      end else begin
         n_edge++;
         tr  = m_q ^ m_qq;
         gap = n_edge - last_edge;
         if (n_edge >= 3 && tr) begin
            if (started && !c && gap > mgap) mgap = (gap > 65535) ? 65535 : gap;
            started   = 1'b1;
            stalled   = 1'b0;
            last_edge = n_edge;
            if (!c) begin
               tcnt++;
               ndiv++;
               if (ndiv % (1 << DL) == 0) hb = ~hb;
            end
         end else if (started && !stalled && gap == TIMEOUT) begin
            stalled = 1'b1;
            if (!c) begin
               if (scnt < 65535) scnt++;
               serr = 1'b1;
            end
         end
         if (c) begin
            tcnt = 0; scnt = 0; mgap = 0; serr = 1'b0; ndiv = 0;
         end
         m_qq = m_q;
         m_q  = b;
      end
   endtask

   task automatic cycle(input logic b, input logic c, input logic r);
      bit_in = b;
      clear  = c;
      rst    = r;
      @(posedge clk);
      model_edge(b, c, r);
      @(negedge clk);
      check("alive",     32'(alive),          32'(started && !stalled));
      check("stall_err", 32'(stall_err),      32'(serr));
      check("heartbeat", 32'(heartbeat_led),  32'(hb));
      check("trans_cnt", 32'(transition_cnt), 32'(tcnt % (1 << CW)));
      check("stall_cnt", 32'(stall_cnt),      32'(scnt));
      check("max_gap",   32'(max_gap),        32'(mgap));
   endtask

   task automatic change_after(input int n, input logic c_last);
      for (int k = 0; k < n - 1; k++) cycle(cur, 1'b0, 1'b0);
      cur = ~cur;
      cycle(cur, c_last, 1'b0);
   endtask

   initial begin
      bit_in = 1'b0; clear = 1'b0; rst = 1'b1; cur = 1'b0;

      // reset, INIT with bit held low, then 10 toggles on consecutive cycles
      cycle(1'b0, 1'b0, 1'b1);
      check("rst_alive", 32'(alive), 32'd0);
      check("rst_cnt",   32'(transition_cnt), 32'd0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      repeat (10) begin
         cur = ~cur;
         cycle(cur, 1'b0, 1'b0);
      end

      // gap of exactly TIMEOUT is legal
      change_after(4, 1'b0);
      check("steady_cnt",  32'(transition_cnt), 32'd10);
      check("steady_gap",  32'(max_gap),        32'd1);
      check("steady_hb",   32'(heartbeat_led),  32'd0);
      check("steady_serr", 32'(stall_err),      32'd0);
      check("steady_alv",  32'(alive),          32'd1);

      // gap of TIMEOUT+1 stalls, next change recovers
      change_after(5, 1'b0);
      cycle(cur, 1'b0, 1'b0);
      check("to_gap",   32'(max_gap),   32'd5);
      check("to_scnt",  32'(stall_cnt), 32'd1);
      check("to_serr",  32'(stall_err), 32'd1);
      check("to_alive", 32'(alive),     32'd1);

      // clear while stalled
      repeat (5) cycle(cur, 1'b0, 1'b0);
      check("stl_alive", 32'(alive), 32'd0);
      cycle(cur, 1'b1, 1'b0);
      check("clr_cnt",   32'(transition_cnt), 32'd0);
      check("clr_scnt",  32'(stall_cnt),      32'd0);
      check("clr_gap",   32'(max_gap),        32'd0);
      check("clr_serr",  32'(stall_err),      32'd0);
      check("clr_alive", 32'(alive),          32'd0);
      cur = ~cur;
      cycle(cur, 1'b0, 1'b0);
      cycle(cur, 1'b0, 1'b0);
      check("rec_alive", 32'(alive),          32'd1);
      check("rec_cnt",   32'(transition_cnt), 32'd1);

      // clear coincident with stall entry
      repeat (3) cycle(cur, 1'b0, 1'b0);
      cycle(cur, 1'b1, 1'b0);
      check("cs_scnt",  32'(stall_cnt), 32'd0);
      check("cs_serr",  32'(stall_err), 32'd0);
      check("cs_alive", 32'(alive),     32'd0);

      // reset mid-run; toggles during INIT must not be counted
      cur = 1'b0;
      cycle(cur, 1'b0, 1'b0);
      repeat (7) begin
         cur = ~cur;
         cycle(cur, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      check("mr_cnt",   32'(transition_cnt), 32'd0);
      check("mr_alive", 32'(alive),          32'd0);
      check("mr_gap",   32'(max_gap),        32'd0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check("init_cnt", 32'(transition_cnt), 32'd0);
      cycle(1'b1, 1'b0, 1'b0);
      check("arm_cnt",   32'(transition_cnt), 32'd1);
      check("arm_alive", 32'(alive),          32'd1);
      cur = 1'b1;

      // 17 counted transitions wrap the 4-bit counter to 1
      cycle(cur, 1'b1, 1'b0);
      repeat (17) begin
         cur = ~cur;
         cycle(cur, 1'b0, 1'b0);
      end
      cycle(cur, 1'b0, 1'b0);
      check("wrap_cnt", 32'(transition_cnt), 32'd1);

      // randomized gaps with occasional clear and reset
      for (int s = 0; s < 800; s++) begin
         int   g;
         logic rc, rr;
         g = $urandom_range(1, 7);
         for (int k = 0; k < g - 1; k++) begin
            rc = ($urandom_range(0, 39) == 0);
            rr = ($urandom_range(0, 299) == 0);
            cycle(cur, rc, rr);
         end
         cur = ~cur;
         rc  = ($urandom_range(0, 39) == 0);
         cycle(cur, rc, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_toggle_monitor.md
Name: debug_toggle_monitor

Overview:
- Liveness monitor placed directly downstream of the free-running 1-bit debug toggle loop.
- Samples the toggling bit and counts its transitions.
- Tracks the largest gap between transitions and flags a stall when the bit stops toggling for longer than a timeout.
- Divides the toggle rate down to a visible heartbeat LED output. Debug/bring-up use only; not in the datapath.

Parameters:
TIMEOUT_CYCLES, 4, maximum legal gap in cycles between transitions; legal range 2..65535
CNT_WIDTH, 32, width of transition counter
DIV_LOG2, 24, heartbeat_led toggles once per 2^DIV_LOG2 counted transitions; minimum 1

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
bit_in  input  1  toggle bit from upstream loop; no defined reset value
clear  input  1  synchronous clear of statistics (counters, sticky flag)
alive  output  1  high while state == RUNNING
stall_err  output  1  sticky: a stall has occurred since last rst/clear
heartbeat_led  output  1  divided heartbeat
transition_cnt  output  CNT_WIDTH  detected transitions, wraps modulo 2^CNT_WIDTH
stall_cnt  output  16  number of RUNNING->STALLED entries, saturates at 65535
max_gap  output  16  largest inter-transition gap in cycles, saturates at 65535

Behaviour:
- Clocking and reset: one clock domain, synchronous active-high reset.
- Reset values: all outputs 0; internal bit_q, bit_qq, gap_cnt, div_cnt 0; state INIT.
- Sampling: bit_q <= bit_in; bit_qq <= bit_q every cycle. trans = bit_q ^ bit_qq.
- Detection latency: a change on bit_in sampled at edge k updates counters at edge k+1.
- States: INIT, ARMED, RUNNING, STALLED.
- INIT: lasts exactly 2 cycles after rst deasserts (sampling pipe fill). trans is ignored. Then go to ARMED.
- ARMED: first trans -> RUNNING. Count the transition. Clear gap_cnt. max_gap is not updated (no previous reference).
- RUNNING:
  - trans: count it, max_gap <= max(max_gap, gap_cnt+1), gap_cnt <= 0.
  - no trans: gap_cnt++ (saturating 16 bit). If gap_cnt+1 == TIMEOUT_CYCLES -> STALLED, stall_cnt++ (saturating), stall_err <= 1.
  - A transition in the same cycle as timeout wins, so no stall occurs.
  - Net effect: gap <= TIMEOUT_CYCLES is legal; gap >= TIMEOUT_CYCLES+1 stalls.
- STALLED: gap_cnt keeps counting (saturating). trans: count it, update max_gap with gap_cnt+1, gap_cnt <= 0, go to RUNNING.
- Gap definition: cycles between consecutive detected transitions. A bit toggling every cycle gives gap 1.
- Heartbeat: div_cnt (DIV_LOG2 bits) increments on every counted transition. When it wraps to 0, heartbeat_led toggles in the same edge.
- clear:
  - Zeroes transition_cnt, stall_cnt, max_gap, stall_err, div_cnt.
  - Does not alter state, gap_cnt, alive, or heartbeat_led.
  - Wins over a simultaneous counter/flag update in the same cycle, including a stall entry. The state change still happens.
- Priority: rst > clear > normal update.
- rst mid-operation: everything returns to reset values. The INIT 2-cycle blanking repeats, so a stale bit_qq cannot create a spurious count.

Test Plan:
(all with TIMEOUT_CYCLES=4, DIV_LOG2=2, CNT_WIDTH=32 unless stated)
- Steady toggling: hold bit_in=0 through rst+2 cycles, then toggle every cycle, 10 changes -> transition_cnt=10, max_gap=1, alive=1 from 2nd edge after first change, heartbeat_led toggles twice (back to 0), stall_err=0.
- Timeout boundary: while RUNNING, change bit_in 4 cycles after previous change -> no stall, max_gap=4. Then change 5 cycles after -> alive=0 at edge where gap_cnt+1=4, stall_cnt=1, stall_err=1. Next change -> alive=1, max_gap=5.
- Clear while STALLED: assert clear 1 cycle -> transition_cnt=0, stall_cnt=0, max_gap=0, stall_err=0, alive stays 0. Next change -> alive=1, transition_cnt=1.
- Clear coincident with stall entry -> stall_cnt=0, stall_err=0, alive=0 (state STALLED).
- Reset mid-run: after 7 transitions assert rst 1 cycle with bit_in=1 while bit_qq=0 -> all outputs 0. Toggle during the 2 INIT cycles is not counted; first count happens in ARMED.
- Wrap (CNT_WIDTH=4): 17 counted transitions -> transition_cnt=1; stall_cnt never wraps (force 65535 entries via long run or shortened-width variant: stays 65535).
